// File: rtl/decode_forward_scoreboard.sv
// rtl/decode_forward_scoreboard.sv - decode-stage operand forwarding scoreboard over in-flight writers.
// Define FWD_STATS_EN to build the saturating stall-cycle counter; otherwise stall_count is tied to 0.
module decode_forward_scoreboard #(
   parameter int NUM_READ = 2,
   parameter int DEPTH    = 6,
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5
) (
   input  logic                             clk,
   input  logic                             resetn,
   input  logic                             advance,
   input  logic                             flush,
   input  logic                             issue_valid,
   input  logic [ADDR_W-1:0]                issue_dst,
   input  logic                             issue_ready,
   input  logic [DATA_W-1:0]                issue_value,
   input  logic                             fill_valid,
   input  logic [$clog2(DEPTH)-1:0]         fill_slot,
   input  logic [DATA_W-1:0]                fill_value,
   input  logic [NUM_READ-1:0][ADDR_W-1:0]  src,
   input  logic [NUM_READ-1:0][DATA_W-1:0]  rf_data,
   output logic [NUM_READ-1:0][DATA_W-1:0]  vr,
   output logic                             stall,
   output logic [31:0]                      stall_count
);

   localparam int SLOT_W = $clog2(DEPTH);

   logic [DEPTH-1:0]  valid_q, valid_d;
   logic [DEPTH-1:0]  ready_q, ready_d;
   logic [ADDR_W-1:0] dst_q   [DEPTH];
   logic [ADDR_W-1:0] dst_d   [DEPTH];
   logic [DATA_W-1:0] value_q [DEPTH];
   logic [DATA_W-1:0] value_d [DEPTH];

   // Slot view with this cycle's fill already merged; both forwarding and shifting use it.
   logic [DEPTH-1:0]  fill_hit;
   logic [DEPTH-1:0]  rdy_f;
   logic [DATA_W-1:0] val_f [DEPTH];

   logic [NUM_READ-1:0] pending;

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         fill_hit[i] = fill_valid && valid_q[i] && (fill_slot == SLOT_W'(i));
         rdy_f[i]    = ready_q[i] | fill_hit[i];
         val_f[i]    = fill_hit[i] ? fill_value : value_q[i];
      end
   end

   always_comb begin
      valid_d = valid_q;
      ready_d = rdy_f;
      dst_d   = dst_q;
      value_d = val_f;
      if (advance) begin
         for (int i = DEPTH - 1; i >= 1; i--) begin
            valid_d[i] = valid_q[i-1];
            ready_d[i] = rdy_f[i-1];
            dst_d[i]   = dst_q[i-1];
            value_d[i] = val_f[i-1];
         end
         // Writes to r0 never become forwarding sources.
         valid_d[0] = issue_valid && (issue_dst != '0);
         ready_d[0] = issue_ready;
         dst_d[0]   = issue_dst;
         value_d[0] = issue_value;
      end
      if (flush) begin
         valid_d = '0;
         ready_d = '0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         valid_q <= '0;
         ready_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            dst_q[i]   <= '0;
            value_q[i] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         ready_q <= ready_d;
         for (int i = 0; i < DEPTH; i++) begin
            dst_q[i]   <= dst_d[i];
            value_q[i] <= value_d[i];
         end
      end
   end

   always_comb begin
      logic              hit;
      logic              hit_rdy;
      logic [DATA_W-1:0] hit_val;
      vr      = rf_data;
      pending = '0;
      for (int p = 0; p < NUM_READ; p++) begin
         hit     = 1'b0;
         hit_rdy = 1'b0;
         hit_val = '0;
         // Scan oldest to youngest so the youngest match wins, pending or not.
         for (int i = DEPTH - 1; i >= 0; i--) begin
            if (valid_q[i] && (dst_q[i] == src[p])) begin
               hit     = 1'b1;
               hit_rdy = rdy_f[i];
               hit_val = val_f[i];
            end
         end
         if (src[p] == '0) begin
            vr[p] = '0;
         end else if (hit) begin
            if (hit_rdy) vr[p] = hit_val;
            else         pending[p] = 1'b1;
         end
      end
   end

   assign stall = |pending;

`ifdef FWD_STATS_EN
   logic [31:0] stall_count_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         stall_count_q <= '0;
      end else if (stall && !flush && (stall_count_q != '1)) begin
         stall_count_q <= stall_count_q + 32'd1;
      end
   end

   assign stall_count = stall_count_q;
`else
   assign stall_count = '0;
`endif

endmodule

// File: tb/tb_decode_forward_scoreboard.sv
// tb/tb_decode_forward_scoreboard.sv - directed scoreboard bench for decode_forward_scoreboard.
module tb_decode_forward_scoreboard;

   localparam logic [31:0] RF0 = 32'hAAAA_0000;
   localparam logic [31:0] RF1 = 32'hBBBB_0000;

   logic             clk = 1'b0;
   logic             resetn;
   logic             advance, flush;
   logic             issue_valid, issue_ready;
   logic [4:0]       issue_dst;
   logic [31:0]      issue_value;
   logic             fill_valid;
   logic [2:0]       fill_slot;
   logic [31:0]      fill_value;
   logic [1:0][4:0]  src;
   logic [1:0][31:0] rf_data;
   logic [1:0][31:0] vr;
   logic             stall;
   logic [31:0]      stall_count;

   typedef struct packed {
      logic [31:0] vr0;
      logic [31:0] vr1;
      logic        stall;
   } exp_t;

   exp_t  sb_q  [$];
   string tag_q [$];

   int          n_assert = 0;
   int          n_fail   = 0;
   logic [31:0] exp_cnt  = 0;
   logic        last_stall = 1'b0;

   decode_forward_scoreboard dut (
      .clk         (clk),
      .resetn      (resetn),
      .advance     (advance),
      .flush       (flush),
      .issue_valid (issue_valid),
      .issue_dst   (issue_dst),
      .issue_ready (issue_ready),
      .issue_value (issue_value),
      .fill_valid  (fill_valid),
      .fill_slot   (fill_slot),
      .fill_value  (fill_value),
      .src         (src),
      .rf_data     (rf_data),
      .vr          (vr),
      .stall       (stall),
      .stall_count (stall_count)
   );

   always #5 clk = ~clk;

   task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] v0, input logic [31:0] v1, input logic st);
      exp_t  e;
      string t;
      sb_q.push_back('{vr0: v0, vr1: v1, stall: st});
      tag_q.push_back(tag);
      last_stall = st;
      #1;
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      cmp({t, ".vr0"},  vr[0], e.vr0);
      cmp({t, ".vr1"},  vr[1], e.vr1);
      cmp({t, ".stall"}, {31'd0, stall}, {31'd0, e.stall});
   endtask

   task automatic issue(input logic [4:0] d, input logic r, input logic [31:0] v);
      issue_valid = 1'b1;
      issue_dst   = d;
      issue_ready = r;
      issue_value = v;
   endtask

   task automatic tick();
`ifdef FWD_STATS_EN
      if (last_stall && !flush && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 1;
`endif
      @(posedge clk);
      #1;
      advance     = 1'b0;
      flush       = 1'b0;
      issue_valid = 1'b0;
      issue_ready = 1'b0;
      fill_valid  = 1'b0;
      last_stall  = 1'b0;
      cmp("stall_count", stall_count, exp_cnt);
   endtask

   task automatic fill(input logic [2:0] s, input logic [31:0] v);
      fill_valid = 1'b1;
      fill_slot  = s;
      fill_value = v;
   endtask

   initial begin
      resetn      = 1'b0;
      advance     = 1'b0;
      flush       = 1'b0;
      issue_valid = 1'b0;
      issue_ready = 1'b0;
      issue_dst   = '0;
      issue_value = '0;
      fill_valid  = 1'b0;
      fill_slot   = '0;
      fill_value  = '0;
      rf_data[0]  = RF0;
      rf_data[1]  = RF1;
      src[0]      = 5'd4;
      src[1]      = 5'd0;
      #2;
      chk("reset", RF0, 32'h0, 1'b0);
      cmp("reset.cnt", stall_count, 32'h0);
      @(negedge clk);
      resetn = 1'b1;
      @(posedge clk);
      #1;

      // Two writers to r3: youngest value wins.
      src[0] = 5'd3;
      issue(5'd3, 1'b1, 32'h11); advance = 1'b1;
      chk("fwd_a", RF0, 32'h0, 1'b0); tick();
      issue(5'd3, 1'b1, 32'h22); advance = 1'b1;
      chk("fwd_b", 32'h11, 32'h0, 1'b0); tick();
      chk("fwd_young", 32'h22, 32'h0, 1'b0); tick();

      // Pending r8 stalls until the late fill arrives, then the value holds.
      src[1] = 5'd8;
      issue(5'd8, 1'b0, 32'h0); advance = 1'b1;
      chk("pend_issue", 32'h22, RF1, 1'b0); tick();
      chk("pend_stall", 32'h22, RF1, 1'b1); tick();
      fill(3'd0, 32'hABCD);
      chk("fill_same", 32'h22, 32'hABCD, 1'b0); tick();
      chk("fill_held", 32'h22, 32'hABCD, 1'b0); tick();

      // Pending young r3 must not fall through to the older ready r3.
      issue(5'd3, 1'b0, 32'h0); advance = 1'b1;
      chk("young_issue", 32'h22, 32'hABCD, 1'b0); tick();
      chk("no_fallthru", RF0, 32'hABCD, 1'b1); tick();
      fill(3'd0, 32'h33); advance = 1'b1;
      chk("fill_adv_same", 32'h33, 32'hABCD, 1'b0); tick();
      chk("fill_landed", 32'h33, 32'hABCD, 1'b0); tick();

      // Writer to r0 never becomes valid; src=0 reads as zero.
      src[0] = 5'd0;
      issue(5'd0, 1'b1, 32'h55); advance = 1'b1;
      chk("zero_issue", 32'h0, 32'hABCD, 1'b0); tick();
      chk("zero_src", 32'h0, 32'hABCD, 1'b0); tick();

      // r5 walks through all slots and retires after DEPTH advances.
      src[1] = 5'd5;
      issue(5'd5, 1'b1, 32'h5555); advance = 1'b1;
      chk("ret_issue", 32'h0, RF1, 1'b0); tick();
      for (int k = 0; k < 6; k++) begin
         advance = 1'b1;
         chk($sformatf("ret_walk%0d", k), 32'h0, 32'h5555, 1'b0); tick();
      end
      chk("ret_gone", 32'h0, RF1, 1'b0); tick();

      // Flush beats a same-cycle advance, issue and fill.
      src[1] = 5'd9;
      issue(5'd9, 1'b0, 32'h0); advance = 1'b1;
      chk("fl_issue", 32'h0, RF1, 1'b0); tick();
      src[0] = 5'd3;
      chk("fl_pend", RF0, RF1, 1'b1); tick();
      flush = 1'b1; advance = 1'b1;
      issue(5'd9, 1'b0, 32'h0);
      fill(3'd0, 32'h99);
      chk("fl_same", RF0, 32'h99, 1'b0); tick();
      chk("fl_after", RF0, RF1, 1'b0); tick();

      // Stall counter: three stalled cycles, then asynchronous reset mid-stall.
      resetn = 1'b0;
      #1;
      resetn = 1'b1;
      exp_cnt = 32'h0;
      cmp("cnt_rst0", stall_count, 32'h0);
      src[0] = 5'd7;
      src[1] = 5'd0;
      issue(5'd7, 1'b0, 32'h0); advance = 1'b1;
      chk("st_issue", RF0, 32'h0, 1'b0); tick();
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("st_stall%0d", k), RF0, 32'h0, 1'b1); tick();
      end
      chk("st_mid", RF0, 32'h0, 1'b1);
`ifdef FWD_STATS_EN
      cmp("cnt_three", stall_count, 32'd3);
`else
      cmp("cnt_tied", stall_count, 32'd0);
`endif
      resetn = 1'b0;
      #1;
      cmp("cnt_async", stall_count, 32'h0);
      chk("rst_mid", RF0, 32'h0, 1'b0);
      resetn = 1'b1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
